// File: rtl/instr_fetch.sv
//------------------------------------------------------------------------------
// Module     : instr_fetch
// Description: Instruction fetch unit. Holds the architectural PC, issues one
//              imem request at a time (valid/ready request, valid-only
//              response) and presents {inst_pc, inst_data} to decode over a
//              valid/ready handshake. Redirects squash in-flight or held
//              fetches; the most recent redirect target wins.
//              Optional build macro: MISALIGN_TRAP_EN. When it is defined, a
//              redirect to a non-word-aligned target raises fetch_fault and
//              parks the unit until reset. When it is undefined, the low two
//              target bits are cleared.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        fetch_fault
);

  localparam logic [31:0] c_ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] c_PC_STEP    = 32'h0000_0004;

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_kill;
  logic        r_req_valid;
  logic [31:0] r_req_addr;
  logic        r_inst_valid;
  logic [31:0] r_inst_data;
  logic [31:0] r_inst_pc;

  // Word-aligned redirect target; the low bits only matter for fault detection.
  logic [31:0] w_redir_pc;
  logic        w_take_redir;
  logic        w_trap;

  assign w_redir_pc = redirect_pc & c_ALIGN_MASK;

`ifdef MISALIGN_TRAP_EN
  logic r_fault;

  assign w_trap       = redirect_valid & (|redirect_pc[1:0]);
  assign w_take_redir = redirect_valid & ~w_trap;
  assign fetch_fault  = r_fault;

  // Sticky misaligned-target fault flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fault <= 1'b0;
    end else if (w_trap && (r_state == S_REQ || r_state == S_WAIT || r_state == S_HOLD)) begin
      r_fault <= 1'b1;
    end
  end
`else
  assign w_trap       = 1'b0;
  assign w_take_redir = redirect_valid;
  assign fetch_fault  = 1'b0;
`endif

  // Fetch FSM: PC, kill flag, request and decode-side outputs all registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_BOOT;
      r_pc         <= RESET_PC;
      r_kill       <= 1'b0;
      r_req_valid  <= 1'b0;
      r_req_addr   <= 32'h0;
      r_inst_valid <= 1'b0;
      r_inst_data  <= 32'h0;
      r_inst_pc    <= 32'h0;
    end else begin
      case (r_state)
        S_BOOT: begin
          r_state     <= S_REQ;
          r_req_valid <= 1'b1;
          r_req_addr  <= r_pc;
        end
        S_REQ: begin
          if (w_trap) begin
            r_state     <= S_FAULT;
            r_req_valid <= 1'b0;
            r_req_addr  <= 32'h0;
          end else if (imem_req_ready) begin
            r_state     <= S_WAIT;
            r_req_valid <= 1'b0;
            r_req_addr  <= 32'h0;
            if (w_take_redir) begin
              r_kill <= 1'b1;
              r_pc   <= w_redir_pc;
            end
          end else if (w_take_redir) begin
            // Request not yet accepted: retarget it, address follows next cycle.
            r_pc       <= w_redir_pc;
            r_req_addr <= w_redir_pc;
          end
        end
        S_WAIT: begin
          if (w_trap) begin
            r_state <= S_FAULT;
            r_kill  <= 1'b0;
          end else if (imem_rsp_valid) begin
            if (r_kill || w_take_redir) begin
              // Stale response: drop it and refetch from the current target.
              r_kill      <= 1'b0;
              r_state     <= S_REQ;
              r_req_valid <= 1'b1;
              r_pc        <= w_take_redir ? w_redir_pc : r_pc;
              r_req_addr  <= w_take_redir ? w_redir_pc : r_pc;
            end else begin
              r_state      <= S_HOLD;
              r_inst_valid <= 1'b1;
              r_inst_data  <= imem_rsp_data;
              r_inst_pc    <= r_pc;
            end
          end else if (w_take_redir) begin
            r_kill <= 1'b1;
            r_pc   <= w_redir_pc;
          end
        end
        S_HOLD: begin
          if (w_trap) begin
            r_state      <= S_FAULT;
            r_inst_valid <= 1'b0;
          end else if (w_take_redir) begin
            r_state      <= S_REQ;
            r_inst_valid <= 1'b0;
            r_pc         <= w_redir_pc;
            r_req_valid  <= 1'b1;
            r_req_addr   <= w_redir_pc;
          end else if (inst_ready) begin
            // PC increment wraps modulo 2^32.
            r_state      <= S_REQ;
            r_inst_valid <= 1'b0;
            r_pc         <= r_pc + c_PC_STEP;
            r_req_valid  <= 1'b1;
            r_req_addr   <= r_pc + c_PC_STEP;
          end
        end
        S_FAULT: begin
          r_req_valid  <= 1'b0;
          r_req_addr   <= 32'h0;
          r_inst_valid <= 1'b0;
        end
        default: begin
          r_state <= S_BOOT;
        end
      endcase
    end
  end

  assign imem_req_valid = r_req_valid;
  assign imem_req_addr  = r_req_addr;
  assign inst_valid     = r_inst_valid;
  assign inst_data      = r_inst_data;
  assign inst_pc        = r_inst_pc;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
//------------------------------------------------------------------------------
// Module     : tb_instr_fetch
// Description: Directed self-checking bench for instr_fetch (RESET_PC=0x100).
//              Honours MISALIGN_TRAP_EN for the misaligned-redirect scenario.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        fetch_fault;

  int vectors;
  int miscompares;

  instr_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .fetch_fault    (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    vectors++;
    if ({imem_req_valid, inst_valid, fetch_fault} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_ctl got req=%b iv=%b ff=%b want 000", imem_req_valid, inst_valid, fetch_fault);
    end
    vectors++;
    if ({imem_req_addr, inst_data, inst_pc} !== 96'h0) begin
      miscompares++;
      $display("FAIL reset_data got addr=%h data=%h pc=%h want zeros", imem_req_addr, inst_data, inst_pc);
    end
    rst = 1'b0;
    step();
    vectors++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
      miscompares++;
      $display("FAIL first_req got v=%b addr=%h want v=1 addr=00000100", imem_req_valid, imem_req_addr);
    end
  endtask

  // Three back-to-back fetches with a one-cycle response and ready decode.
  task automatic test_basic_fetch();
    logic [31:0] exp_pc;
    exp_pc = 32'h100;
    for (int i = 0; i < 3; i++) begin
      imem_req_ready = 1'b1;
      step();
      imem_req_ready = 1'b0;
      vectors++;
      if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL basic_wait[%0d] got req=%b iv=%b want 0 0", i, imem_req_valid, inst_valid);
      end
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h0050_0093;
      step();
      imem_rsp_valid = 1'b0;
      vectors++;
      if (inst_valid !== 1'b1 || inst_pc !== exp_pc || inst_data !== 32'h0050_0093) begin
        miscompares++;
        $display("FAIL basic_inst[%0d] got v=%b pc=%h d=%h want 1 %h 00500093", i, inst_valid, inst_pc, inst_data, exp_pc);
      end
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      exp_pc = exp_pc + 32'h4;
      vectors++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc || inst_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL basic_next[%0d] got v=%b addr=%h iv=%b want 1 %h 0", i, imem_req_valid, imem_req_addr, inst_valid, exp_pc);
      end
    end
  endtask

  // Decode stalls in HOLD for five cycles; entered in REQ at 0x10C.
  task automatic test_decode_stall();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    step();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h1111_1111;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (inst_valid !== 1'b1 || inst_data !== 32'hDEAD_BEEF || inst_pc !== 32'h10C || imem_req_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL stall[%0d] got iv=%b d=%h pc=%h req=%b want 1 deadbeef 0000010c 0", i, inst_valid, inst_data, inst_pc, imem_req_valid);
      end
    end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    vectors++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h110) begin
      miscompares++;
      $display("FAIL stall_release got v=%b addr=%h want 1 00000110", imem_req_valid, imem_req_addr);
    end
  endtask

  // Redirect during WAIT; the old response must be squashed. Entered in REQ at 0x110.
  task automatic test_redirect_wait();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    step();
    redirect_valid = 1'b0;
    step();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_BAD0;
    step();
    imem_rsp_valid = 1'b0;
    vectors++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
      miscompares++;
      $display("FAIL redir_wait got iv=%b req=%b addr=%h want 0 1 00000200", inst_valid, imem_req_valid, imem_req_addr);
    end
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0013;
    step();
    imem_rsp_valid = 1'b0;
    vectors++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h200 || inst_data !== 32'h0000_0013) begin
      miscompares++;
      $display("FAIL redir_wait_inst got v=%b pc=%h d=%h want 1 00000200 00000013", inst_valid, inst_pc, inst_data);
    end
  endtask

  // Redirect coincides with inst_ready in HOLD (entered in HOLD at 0x200).
  task automatic test_redirect_hold();
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    step();
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    vectors++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300) begin
      miscompares++;
      $display("FAIL redir_hold got iv=%b req=%b addr=%h want 0 1 00000300", inst_valid, imem_req_valid, imem_req_addr);
    end
  endtask

  // Redirect accepted with the request, then two redirects in WAIT: last target wins.
  task automatic test_back_to_back();
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h500;
    step();
    imem_req_ready = 1'b0;
    redirect_pc    = 32'h600;
    step();
    redirect_pc    = 32'h700;
    step();
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD1_BAD1;
    step();
    imem_rsp_valid = 1'b0;
    vectors++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h700) begin
      miscompares++;
      $display("FAIL last_redir got iv=%b req=%b addr=%h want 0 1 00000700", inst_valid, imem_req_valid, imem_req_addr);
    end
  endtask

  // Retarget an unaccepted request to the top word, then wrap on handshake.
  task automatic test_pc_wrap();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    vectors++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin
      miscompares++;
      $display("FAIL retarget got v=%b addr=%h want 1 fffffffc", imem_req_valid, imem_req_addr);
    end
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_006F;
    step();
    imem_rsp_valid = 1'b0;
    vectors++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC) begin
      miscompares++;
      $display("FAIL wrap_inst got v=%b pc=%h want 1 fffffffc", inst_valid, inst_pc);
    end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    vectors++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_next got v=%b addr=%h want 1 00000000", imem_req_valid, imem_req_addr);
    end
  endtask

  // Reset while a response is outstanding; the late response must be ignored.
  task automatic test_mid_reset();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset got req=%b iv=%b want 0 0", imem_req_valid, inst_valid);
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD2_BAD2;
    step();
    imem_rsp_valid = 1'b0;
    step();
    vectors++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
      miscompares++;
      $display("FAIL post_reset got iv=%b req=%b addr=%h want 0 1 00000100", inst_valid, imem_req_valid, imem_req_addr);
    end
  endtask

  // Misaligned redirect issued while in REQ at 0x100.
  task automatic test_misaligned();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h402;
    step();
    redirect_valid = 1'b0;
`ifdef MISALIGN_TRAP_EN
    vectors++;
    if (fetch_fault !== 1'b1 || imem_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL trap got ff=%b req=%b want 1 0", fetch_fault, imem_req_valid);
    end
    imem_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if (fetch_fault !== 1'b1 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL trap_hold[%0d] got ff=%b req=%b iv=%b want 1 0 0", i, fetch_fault, imem_req_valid, inst_valid);
      end
    end
    imem_req_ready = 1'b0;
`else
    vectors++;
    if (fetch_fault !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h400) begin
      miscompares++;
      $display("FAIL align got ff=%b req=%b addr=%h want 0 1 00000400", fetch_fault, imem_req_valid, imem_req_addr);
    end
`endif
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b0;
    #1;
    test_reset();
    test_basic_fetch();
    test_decode_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_back_to_back();
    test_pc_wrap();
    test_mid_reset();
    test_misaligned();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired after 100000 ns, vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
